// File: rtl/memory_bank_if.sv
// Bus between the calculator core and memory_bank.
//   master: drives key0/key1/current_result, observes the bank state.
//   slave : the bank itself.
//   key0/key1      raw active-high keys, asynchronous to clk
//   current_result value offered for saving
//   memory_result  slot at read_index, 0 when that slot is empty
//   read_index     slot currently presented
//   entry_count    number of valid slots, 0..DEPTH
//   mem_full       entry_count == DEPTH
//   memory_clear   sticky flag set by a long-press clear
//   save_pulse     one-cycle pulse on a committed save
interface memory_bank_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned CW = IW + 1;

  logic             key0;
  logic             key1;
  logic [WIDTH-1:0] current_result;
  logic [WIDTH-1:0] memory_result;
  logic [IW-1:0]    read_index;
  logic [CW-1:0]    entry_count;
  logic             mem_full;
  logic             memory_clear;
  logic             save_pulse;

  modport master (
    output key0, key1, current_result,
    input  memory_result, read_index, entry_count, mem_full, memory_clear, save_pulse
  );

  modport slave (
    input  key0, key1, current_result,
    output memory_result, read_index, entry_count, mem_full, memory_clear, save_pulse
  );
endinterface

// File: rtl/memory_bank.sv
// Circular result bank: key0 short press saves current_result, key0 long hold
// clears the bank, key1 presses step recall from newest to oldest entry.
// Ports:
//   clk   rising-edge clock
//   reset asynchronous active-low reset
//   bus   memory_bank_if slave (keys, value to save, bank outputs)
module memory_bank #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned HOLD_CYCLES = 500000000,
  parameter int unsigned CNT_W       = 32
) (
  input  logic         clk,
  input  logic         reset,
  memory_bank_if.slave bus
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned CW = IW + 1;

  typedef enum logic [1:0] {IDLE, HOLD, LONG} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_n;

  logic k0_meta, k0s, k1_meta, k1s, k1s_d;
  logic k1_rise;

  logic [WIDTH-1:0] slot   [DEPTH];
  logic [WIDTH-1:0] slot_n [DEPTH];
  logic [DEPTH-1:0] valid, valid_n;
  logic [IW-1:0]    wr_ptr, wr_ptr_n;
  logic [IW-1:0]    rd_idx, rd_idx_n;
  logic [CW-1:0]    count, count_n;
  logic             clear_flag, clear_flag_n;
  logic             pulse_n;
  logic             do_save, do_clear;

  logic [WIDTH-1:0] result_q;
  logic             full_q, pulse_q;

  // Two-flop synchronizers for the raw keys plus key1 edge history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k0_meta <= 1'b0;
      k0s     <= 1'b0;
      k1_meta <= 1'b0;
      k1s     <= 1'b0;
      k1s_d   <= 1'b0;
    end else begin
      k0_meta <= bus.key0;
      k0s     <= k0_meta;
      k1_meta <= bus.key1;
      k1s     <= k1_meta;
      k1s_d   <= k1s;
    end
  end

  assign k1_rise = k1s & ~k1s_d;

  // Next-state: key0 press FSM, then bank update with clear > save > recall.
  always_comb begin
    state_n      = state;
    hold_cnt_n   = hold_cnt;
    slot_n       = slot;
    valid_n      = valid;
    wr_ptr_n     = wr_ptr;
    rd_idx_n     = rd_idx;
    count_n      = count;
    clear_flag_n = clear_flag;
    pulse_n      = 1'b0;
    do_save      = 1'b0;
    do_clear     = 1'b0;

    unique case (state)
      IDLE: begin
        if (k0s) begin
          state_n    = HOLD;
          hold_cnt_n = CNT_W'(1);
        end
      end
      HOLD: begin
        if (!k0s) begin
          do_save    = 1'b1;
          state_n    = IDLE;
          hold_cnt_n = '0;
        end else if (hold_cnt >= CNT_W'(HOLD_CYCLES - 1)) begin
          // The increment that reaches HOLD_CYCLES is the clear cycle.
          do_clear   = 1'b1;
          state_n    = LONG;
          hold_cnt_n = CNT_W'(HOLD_CYCLES);
        end else begin
          hold_cnt_n = hold_cnt + CNT_W'(1);
        end
      end
      LONG: begin
        if (!k0s) begin
          state_n    = IDLE;
          hold_cnt_n = '0;
        end
      end
      default: begin
        state_n    = IDLE;
        hold_cnt_n = '0;
      end
    endcase

    if (do_clear) begin
      slot_n       = '{default: '0};
      valid_n      = '0;
      wr_ptr_n     = '0;
      rd_idx_n     = '0;
      count_n      = '0;
      clear_flag_n = 1'b1;
    end else if (do_save) begin
      slot_n[wr_ptr]  = bus.current_result;
      valid_n[wr_ptr] = 1'b1;
      rd_idx_n        = wr_ptr;
      wr_ptr_n        = wr_ptr + IW'(1);
      count_n         = (count == CW'(DEPTH)) ? count : count + CW'(1);
      clear_flag_n    = 1'b0;
      pulse_n         = 1'b1;
    end else if (k1_rise) begin
      clear_flag_n = 1'b0;
      // Valid slots are 0..count-1 until the bank fills, so wrap to count-1.
      if (count != '0) begin
        rd_idx_n = (rd_idx == '0) ? IW'(count - CW'(1)) : rd_idx - IW'(1);
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      slot       <= '{default: '0};
      valid      <= '0;
      wr_ptr     <= '0;
      rd_idx     <= '0;
      count      <= '0;
      clear_flag <= 1'b0;
      result_q   <= '0;
      full_q     <= 1'b0;
      pulse_q    <= 1'b0;
    end else begin
      state      <= state_n;
      hold_cnt   <= hold_cnt_n;
      slot       <= slot_n;
      valid      <= valid_n;
      wr_ptr     <= wr_ptr_n;
      rd_idx     <= rd_idx_n;
      count      <= count_n;
      clear_flag <= clear_flag_n;
      result_q   <= valid_n[rd_idx_n] ? slot_n[rd_idx_n] : '0;
      full_q     <= (count_n == CW'(DEPTH));
      pulse_q    <= pulse_n;
    end
  end

  assign bus.memory_result = result_q;
  assign bus.read_index    = rd_idx;
  assign bus.entry_count   = count;
  assign bus.mem_full      = full_q;
  assign bus.memory_clear  = clear_flag;
  assign bus.save_pulse    = pulse_q;

endmodule

// File: tb/tb_memory_bank.sv
// Testbench for memory_bank: vector table, latency/corner sequences and a
// randomized run against a slot-array reference model.
module tb_memory_bank;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned HOLD  = 16;
  localparam int SETTLE = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  memory_bank_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  memory_bank #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .CNT_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int pulse_total = 0;

  always @(negedge clk) if (bus.save_pulse === 1'b1) pulse_total++;

  typedef enum int {OP_RST, OP_KEY0, OP_KEY1} op_e;
  typedef struct {
    op_e        op;
    int         len;
    logic [7:0] val;
    logic [7:0] e_res;
    int         e_idx;
    int         e_cnt;
    int         e_full;
    int         e_clr;
    int         e_pulse;
  } vec_t;

  vec_t vecs[$];

  // Reference model: slots 0..cnt-1 hold data until the bank fills.
  logic [7:0] m_slot [DEPTH];
  int m_cnt, m_wr, m_rd, m_clr;

  task automatic m_reset();
    for (int i = 0; i < int'(DEPTH); i++) m_slot[i] = 8'h00;
    m_cnt = 0; m_wr = 0; m_rd = 0; m_clr = 0;
  endtask

  task automatic m_key0(input int len, input logic [7:0] v);
    if (len >= int'(HOLD)) begin
      m_reset();
      m_clr = 1;
    end else begin
      m_slot[m_wr] = v;
      m_rd = m_wr;
      m_wr = (m_wr + 1) % int'(DEPTH);
      if (m_cnt < int'(DEPTH)) m_cnt++;
      m_clr = 0;
    end
  endtask

  task automatic m_key1();
    m_clr = 0;
    if (m_cnt > 0) m_rd = (m_rd == 0) ? m_cnt - 1 : m_rd - 1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int res, input int idx, input int cnt,
                         input int full, input int clr, input int pulses, input int p0);
    chk({tag, " memory_result"}, int'(bus.memory_result), res);
    chk({tag, " read_index"}, int'(bus.read_index), idx);
    chk({tag, " entry_count"}, int'(bus.entry_count), cnt);
    chk({tag, " mem_full"}, int'(bus.mem_full), full);
    chk({tag, " memory_clear"}, int'(bus.memory_clear), clr);
    chk({tag, " save_pulses"}, pulse_total - p0, pulses);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.key0 = 1'b0;
    bus.key1 = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic press(input int which, input int len);
    @(negedge clk);
    if (which == 0) bus.key0 = 1'b1; else bus.key1 = 1'b1;
    repeat (len) @(negedge clk);
    if (which == 0) bus.key0 = 1'b0; else bus.key1 = 1'b0;
    repeat (SETTLE) @(negedge clk);
  endtask

  int p0;
  int r_len;
  logic [7:0] r_val;

  initial begin
    bus.key0 = 1'b0;
    bus.key1 = 1'b0;
    bus.current_result = 8'h00;

    vecs.push_back('{OP_RST,  0, 8'h00, 8'h00, 0, 0, 0, 0, 0});
    vecs.push_back('{OP_KEY0, 5, 8'h2A, 8'h2A, 0, 1, 0, 0, 1});
    vecs.push_back('{OP_RST,  0, 8'h00, 8'h00, 0, 0, 0, 0, 0});
    vecs.push_back('{OP_KEY0, 3, 8'h11, 8'h11, 0, 1, 0, 0, 1});
    vecs.push_back('{OP_KEY0, 3, 8'h22, 8'h22, 1, 2, 0, 0, 1});
    vecs.push_back('{OP_KEY0, 3, 8'h33, 8'h33, 2, 3, 0, 0, 1});
    vecs.push_back('{OP_KEY0, 3, 8'h44, 8'h44, 3, 4, 1, 0, 1});
    vecs.push_back('{OP_KEY0, 3, 8'h55, 8'h55, 0, 4, 1, 0, 1});
    vecs.push_back('{OP_KEY1, 2, 8'h00, 8'h44, 3, 4, 1, 0, 0});
    vecs.push_back('{OP_KEY1, 2, 8'h00, 8'h33, 2, 4, 1, 0, 0});
    vecs.push_back('{OP_KEY1, 2, 8'h00, 8'h22, 1, 4, 1, 0, 0});
    vecs.push_back('{OP_KEY1, 2, 8'h00, 8'h55, 0, 4, 1, 0, 0});
    vecs.push_back('{OP_RST,  0, 8'h00, 8'h00, 0, 0, 0, 0, 0});
    vecs.push_back('{OP_KEY0, 3, 8'hA0, 8'hA0, 0, 1, 0, 0, 1});
    vecs.push_back('{OP_KEY0, 3, 8'hB0, 8'hB0, 1, 2, 0, 0, 1});
    vecs.push_back('{OP_KEY1, 2, 8'h00, 8'hA0, 0, 2, 0, 0, 0});
    vecs.push_back('{OP_KEY1, 2, 8'h00, 8'hB0, 1, 2, 0, 0, 0});
    vecs.push_back('{OP_KEY1, 2, 8'h00, 8'hA0, 0, 2, 0, 0, 0});
    vecs.push_back('{OP_KEY1, 20, 8'h00, 8'hB0, 1, 2, 0, 0, 0});
    vecs.push_back('{OP_KEY0, 3, 8'hC0, 8'hC0, 2, 3, 0, 0, 1});
    vecs.push_back('{OP_KEY0, 25, 8'h77, 8'h00, 0, 0, 0, 1, 0});
    vecs.push_back('{OP_KEY1, 2, 8'h00, 8'h00, 0, 0, 0, 0, 0});
    vecs.push_back('{OP_KEY0, 15, 8'h12, 8'h12, 0, 1, 0, 0, 1});
    vecs.push_back('{OP_KEY0, 16, 8'h34, 8'h00, 0, 0, 0, 1, 0});

    foreach (vecs[i]) begin
      p0 = pulse_total;
      bus.current_result = vecs[i].val;
      case (vecs[i].op)
        OP_RST:  do_reset();
        OP_KEY0: press(0, vecs[i].len);
        default: press(1, vecs[i].len);
      endcase
      chk_all($sformatf("vec%0d", i), int'(vecs[i].e_res), vecs[i].e_idx, vecs[i].e_cnt,
              vecs[i].e_full, vecs[i].e_clr, vecs[i].e_pulse, p0);
    end

    // Save latency: pulse exactly on the third edge after release.
    do_reset();
    bus.current_result = 8'h5A;
    p0 = pulse_total;
    @(negedge clk) bus.key0 = 1'b1;
    repeat (4) @(negedge clk);
    bus.key0 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("save_lat pulse k%0d", k), int'(bus.save_pulse), (k == 3) ? 1 : 0);
      chk($sformatf("save_lat result k%0d", k), int'(bus.memory_result), (k >= 3) ? 'h5A : 0);
    end

    // Recall latency.
    bus.current_result = 8'h6B;
    press(0, 3);
    @(negedge clk) bus.key1 = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("recall_lat idx k%0d", k), int'(bus.read_index), (k == 3) ? 0 : 1);
    end
    bus.key1 = 1'b0;
    repeat (SETTLE) @(negedge clk);

    // Clear timing: HOLD sampled-high cycles, then output three edges in.
    p0 = pulse_total;
    @(negedge clk) bus.key0 = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (k == 17) chk("clear_lat before", int'(bus.memory_clear), 0);
      if (k == 18) chk("clear_lat at", int'(bus.memory_clear), 1);
    end
    bus.key0 = 1'b0;
    repeat (SETTLE) @(negedge clk);
    chk_all("clear_release", 0, 0, 0, 0, 1, 0, p0);

    // Save and recall in the same cycle: save wins, held key1 adds no step.
    do_reset();
    bus.current_result = 8'hA1; press(0, 3);
    bus.current_result = 8'hB2; press(0, 3);
    press(1, 2);
    bus.current_result = 8'hC3;
    p0 = pulse_total;
    @(negedge clk) bus.key0 = 1'b1;
    repeat (3) @(negedge clk);
    bus.key0 = 1'b0;
    bus.key1 = 1'b1;
    repeat (12) @(negedge clk);
    bus.key1 = 1'b0;
    repeat (SETTLE) @(negedge clk);
    chk_all("save_beats_recall", 'hC3, 2, 3, 0, 0, 1, p0);

    // Reset during a hold aborts it.
    do_reset();
    p0 = pulse_total;
    @(negedge clk) bus.key0 = 1'b1;
    repeat (10) @(negedge clk);
    bus.key0 = 1'b0;
    reset = 1'b0;
    @(negedge clk) reset = 1'b1;
    repeat (SETTLE) @(negedge clk);
    chk_all("reset_mid_hold", 0, 0, 0, 0, 0, 0, p0);
    bus.current_result = 8'h3C;
    p0 = pulse_total;
    press(0, 3);
    chk_all("after_abort_save", 'h3C, 0, 1, 0, 0, 1, p0);

    // Randomized operations against the reference model.
    do_reset();
    m_reset();
    for (int n = 0; n < 60; n++) begin
      p0 = pulse_total;
      if ($urandom_range(2, 0) != 0) begin
        r_len = ($urandom_range(4, 0) == 0) ? int'($urandom_range(20, 16))
                                            : int'($urandom_range(15, 1));
        r_val = 8'($urandom);
        bus.current_result = r_val;
        press(0, r_len);
        m_key0(r_len, r_val);
        chk_all($sformatf("rand%0d key0 len%0d", n, r_len),
                (m_rd < m_cnt) ? int'(m_slot[m_rd]) : 0, m_rd, m_cnt,
                (m_cnt == int'(DEPTH)) ? 1 : 0, m_clr, (r_len < int'(HOLD)) ? 1 : 0, p0);
      end else begin
        r_len = int'($urandom_range(6, 1));
        press(1, r_len);
        m_key1();
        chk_all($sformatf("rand%0d key1", n),
                (m_rd < m_cnt) ? int'(m_slot[m_rd]) : 0, m_rd, m_cnt,
                (m_cnt == int'(DEPTH)) ? 1 : 0, m_clr, 0, p0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
